// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch request controller for the core front end.
// Arbitrates prioritised redirects, sequential stepping (2/4 bytes) and a valid/ready fetch handshake.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              NRED     = 4,
  parameter bit              C_EXT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRED-1:0]      redirect_valid,
  input  logic [NRED*PC_W-1:0] redirect_pc,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 step_half,
  output logic                 fetch_req_valid,
  output logic [PC_W-1:0]      fetch_req_pc,
  input  logic                 fetch_req_ready,
  output logic [NRED-1:0]      redirect_ack,
  output logic                 redirect_misalign
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Low PC bits that must be zero: bit 0 with compressed support, bits 1:0 without.
  localparam logic [PC_W-1:0] LOW_MASK = C_EXT ? PC_W'(1) : PC_W'(3);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [NRED-1:0]   ack_q, ack_d;
  logic              mis_q, mis_d;

  logic              red_any;
  logic [NRED-1:0]   red_onehot;
  logic [PC_W-1:0]   red_target;
  logic [PC_W-1:0]   step_amt;
  logic              fire;

  // Priority encoder: scanning downward lets the lowest set index overwrite the rest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    red_onehot = '0;
    red_target = '0;
    for (int i = NRED - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        red_onehot    = '0;
        red_onehot[i] = 1'b1;
        red_target    = redirect_pc[i*PC_W +: PC_W];
      end
    end
  end

  assign red_any  = |redirect_valid;
  assign step_amt = (C_EXT && step_half) ? PC_W'(2) : PC_W'(4);
  assign fire     = valid_q & fetch_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ack_d   = '0;
    mis_d   = 1'b0;
    if (red_any) begin
      // A redirect overrides stall, halt and any pending unaccepted request.
      state_d = FETCH;
      pc_d    = red_target & ~LOW_MASK;
      valid_d = 1'b1;
      ack_d   = red_onehot;
      mis_d   = |(red_target & LOW_MASK);
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = FETCH;
          valid_d = 1'b1;
        end
        FETCH: begin
          valid_d = 1'b1;
          if (fire && !stall) pc_d = pc_q + step_amt;
          if (halt) begin
            state_d = HALTED;
            valid_d = 1'b0;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ack_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      mis_q   <= mis_d;
    end
  end

  assign fetch_req_valid   = valid_q;
  assign fetch_req_pc      = pc_q;
  assign redirect_ack      = ack_q;
  assign redirect_misalign = mis_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: two instances (compressed and 4-byte-only) share stimulus;
// expected outputs are queued per cycle and compared by an independent negedge monitor.
module tb_pc_fetch_ctrl;

  localparam int PC_W = 32;
  localparam int NRED = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRED-1:0]   rv;
  logic [NRED*PC_W-1:0] rpc;
  logic              stall, halt, step_half, ready;

  logic              va, vb, ma, mb;
  logic [PC_W-1:0]   pa, pb;
  logic [NRED-1:0]   aa, ab;

  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC), .NRED(NRED), .C_EXT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .redirect_valid(rv), .redirect_pc(rpc), .stall(stall),
    .halt(halt), .step_half(step_half), .fetch_req_valid(va), .fetch_req_pc(pa),
    .fetch_req_ready(ready), .redirect_ack(aa), .redirect_misalign(ma));

  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC), .NRED(NRED), .C_EXT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .redirect_valid(rv), .redirect_pc(rpc), .stall(stall),
    .halt(halt), .step_half(step_half), .fetch_req_valid(vb), .fetch_req_pc(pb),
    .fetch_req_ready(ready), .redirect_ack(ab), .redirect_misalign(mb));

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          sel_w;
    logic [37:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got v=%b pc=%h ack=%b mis=%b, expected v=%b pc=%h ack=%b mis=%b",
               name, act[37], act[36:5], act[4:1], act[0], exp[37], exp[36:5], exp[4:1], exp[0]);
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares against the selected instance.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else if (e.sel_w) begin
        check(e.name, {vb, pb, ab, mb}, e.exp);
      end else begin
        check(e.name, {va, pa, aa, ma}, e.exp);
      end
    end
  end

  task automatic exp_c(input string n, input logic v, input logic [31:0] pc,
                       input logic [3:0] ack, input logic mis);
    sb.push_back('{cyc + 1, 1'b0, {v, pc, ack, mis}, n});
  endtask

  task automatic exp_w(input string n, input logic v, input logic [31:0] pc,
                       input logic [3:0] ack, input logic mis);
    sb.push_back('{cyc + 1, 1'b1, {v, pc, ack, mis}, n});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_red(input int idx, input logic [31:0] target);
    rv[idx] = 1'b1;
    rpc[idx*PC_W +: PC_W] = target;
  endtask

  task automatic clr_red();
    rv  = '0;
    rpc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rv = '0; rpc = '0; stall = 1'b0; halt = 1'b0; step_half = 1'b0; ready = 1'b1;

    // Reset and boot sequence
    exp_c("reset_c", 1'b0, RST_PC, 4'b0000, 1'b0);
    exp_w("reset_w", 1'b0, RST_PC, 4'b0000, 1'b0);
    step();
    rst = 1'b0;
    exp_c("boot_first_req", 1'b1, 32'h8000_0000, 4'b0000, 1'b0); step();
    exp_c("seq_4",          1'b1, 32'h8000_0004, 4'b0000, 1'b0);
    exp_w("seq_4_w",        1'b1, 32'h8000_0004, 4'b0000, 1'b0); step();
    exp_c("seq_8",          1'b1, 32'h8000_0008, 4'b0000, 1'b0); step();

    // Backpressure then stall
    set_red(3, 32'h0000_0100);
    exp_c("redir_100", 1'b1, 32'h100, 4'b1000, 1'b0); step();
    clr_red();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stall = k[0];
      exp_c("bp_hold", 1'b1, 32'h100, 4'b0000, 1'b0);
      step();
    end
    ready = 1'b1; stall = 1'b1;
    exp_c("stall_reissue", 1'b1, 32'h100, 4'b0000, 1'b0); step();
    stall = 1'b0;
    exp_c("after_stall", 1'b1, 32'h104, 4'b0000, 1'b0); step();

    // Priority between simultaneous sources
    set_red(1, 32'h200); set_red(2, 32'h300); rv[3] = 1'b0; rpc[3*PC_W +: PC_W] = 32'hDEAD_BEE0;
    exp_c("prio_1_over_2", 1'b1, 32'h200, 4'b0010, 1'b0);
    exp_w("prio_1_over_2_w", 1'b1, 32'h200, 4'b0010, 1'b0); step();
    clr_red();

    // Compressed stepping and alignment, back-to-back redirects
    step_half = 1'b1;
    exp_c("half_step", 1'b1, 32'h202, 4'b0000, 1'b0);
    exp_w("half_ignored_w", 1'b1, 32'h204, 4'b0000, 1'b0); step();
    step_half = 1'b0;
    set_red(0, 32'h403);
    exp_c("misalign_403", 1'b1, 32'h402, 4'b0001, 1'b1);
    exp_w("misalign_403_w", 1'b1, 32'h400, 4'b0001, 1'b1); step();
    clr_red(); set_red(2, 32'h402);
    exp_c("aligned_402", 1'b1, 32'h402, 4'b0100, 1'b0);
    exp_w("misalign_402_w", 1'b1, 32'h400, 4'b0100, 1'b1); step();
    clr_red();

    // Halt with handshake, held while halted, exit by redirect
    set_red(3, 32'h500);
    exp_c("redir_500", 1'b1, 32'h500, 4'b1000, 1'b0); step();
    clr_red(); halt = 1'b1;
    exp_c("halt_enter", 1'b0, 32'h504, 4'b0000, 1'b0);
    exp_w("halt_enter_w", 1'b0, 32'h504, 4'b0000, 1'b0); step();
    halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stall = k[0]; step_half = k[1];
      exp_c("halted_hold", 1'b0, 32'h504, 4'b0000, 1'b0);
      step();
    end
    stall = 1'b0; step_half = 1'b0;
    set_red(1, 32'h600);
    exp_c("halt_exit", 1'b1, 32'h600, 4'b0010, 1'b0); step();
    clr_red(); set_red(2, 32'h700); halt = 1'b1;
    exp_c("halt_plus_redir", 1'b1, 32'h700, 4'b0100, 1'b0); step();
    clr_red(); halt = 1'b0; ready = 1'b0;
    exp_c("fetch_after_hr", 1'b1, 32'h700, 4'b0000, 1'b0); step();

    // Wrap and mid-operation reset
    ready = 1'b1;
    set_red(3, 32'hFFFF_FFFC);
    exp_c("redir_top", 1'b1, 32'hFFFF_FFFC, 4'b1000, 1'b0); step();
    clr_red();
    exp_c("wrap", 1'b1, 32'h0000_0000, 4'b0000, 1'b0);
    exp_w("wrap_w", 1'b1, 32'h0000_0000, 4'b0000, 1'b0); step();
    ready = 1'b0;
    exp_c("hold_zero", 1'b1, 32'h0, 4'b0000, 1'b0); step();
    rst = 1'b1; set_red(0, 32'h900); halt = 1'b1;
    exp_c("midop_reset", 1'b0, RST_PC, 4'b0000, 1'b0);
    exp_w("midop_reset_w", 1'b0, RST_PC, 4'b0000, 1'b0); step();
    rst = 1'b0; clr_red(); halt = 1'b0; ready = 1'b1;
    exp_c("reboot", 1'b1, RST_PC, 4'b0000, 1'b0); step();

    step(); step();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations never compared", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
